// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem request outstanding,
// and buffers the returned word for the IF/ID register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_plus4_out,
  output logic        fetch_valid
);

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        kill_q, kill_d;
  logic        fv_q, fv_d;

  logic        req_fire;
  logic        resp_hit;
  logic        resp_load;

  // Only request when the buffer is free (or draining) so a reply never lands on held data.
  always_comb begin
    imem_req_valid = reset && (state_q == S_REQ) && (!fv_q || !stall) && !redirect_valid;
  end

  always_comb begin
    req_fire  = imem_req_valid && imem_req_ready;
    resp_hit  = (state_q == S_WAIT) && imem_resp_valid;
    resp_load = resp_hit && !kill_q && !redirect_valid;

    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    kill_d   = kill_q;
    fv_d     = fv_q;

    if (fv_q && !stall) begin
      fv_d = 1'b0;
    end

    if (req_fire) begin
      req_pc_d = pc_q;
      state_d  = S_WAIT;
    end

    if (resp_hit) begin
      state_d = S_REQ;
      kill_d  = 1'b0;
      if (resp_load) begin
        instr_d = imem_resp_data;
        pc4_d   = req_pc_q + 32'd4;
        pc_d    = req_pc_q + 32'd4;
        fv_d    = 1'b1;
      end
    end

    // A redirect flushes the buffer; if a request is still in flight its reply must be dropped.
    if (redirect_valid) begin
      pc_d = redirect_pc & ~32'd3;
      fv_d = 1'b0;
      if (((state_q == S_WAIT) && !imem_resp_valid) || req_fire) begin
        kill_d  = 1'b1;
        state_d = S_WAIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= 32'd0;
      instr_q  <= 32'd0;
      pc4_q    <= 32'd0;
      kill_q   <= 1'b0;
      fv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      kill_q   <= kill_d;
      fv_q     <= fv_d;
    end
  end

  assign imem_req_addr   = pc_q;
  assign instruction_out = instr_q;
  assign pc_plus4_out    = pc4_q;
  assign fetch_valid     = fv_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a simple memory responder, a transaction-level
// reference model checked every cycle, and literal checkpoints along the sequence.
module tb_if_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'd0;
  logic [31:0] instruction_out;
  logic [31:0] pc_plus4_out;
  logic        fetch_valid;

  int vectors = 0;
  int miscompares = 0;

  if_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .instruction_out(instruction_out),
    .pc_plus4_out   (pc_plus4_out),
    .fetch_valid    (fetch_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hAAAA_0001;
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory: answers mem_delay cycles after the handshake edge.
  int          mem_delay = 1;
  int          mem_cnt = 0;
  bit          mem_busy = 0;
  logic [31:0] mem_addr = 32'd0;
  always @(posedge clk) begin
    bit          hs;
    logic [31:0] a;
    hs = imem_req_valid && imem_req_ready;
    a  = imem_req_addr;
    #1;
    imem_resp_valid = 1'b0;
    if (hs) begin
      mem_busy = 1;
      mem_cnt  = mem_delay;
      mem_addr = a;
    end
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = memfn(mem_addr);
        mem_busy        = 0;
      end
    end
  end

  // Reference model: next fetch address, one outstanding request, one buffered instruction.
  bit          chk_en = 0;
  bit          m_busy = 0;
  bit          m_kill = 0;
  bit          m_fv = 0;
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_raddr = 32'd0;
  logic [31:0] m_ins = 32'd0;
  logic [31:0] m_pc4 = 32'd0;
  always @(posedge clk) begin
    bit can_req;
    bit loaded;
    if (!reset) begin
      m_pc   = RPC;
      m_busy = 0;
      m_kill = 0;
      m_fv   = 0;
      m_ins  = 32'd0;
      m_pc4  = 32'd0;
      chk_en = 1;
    end else begin
      can_req = !m_busy && (!m_fv || !stall) && !redirect_valid;
      loaded  = 0;
      if (m_busy && imem_resp_valid) begin
        if (!m_kill && !redirect_valid) begin
          m_ins  = imem_resp_data;
          m_pc4  = m_raddr + 32'd4;
          m_pc   = m_raddr + 32'd4;
          loaded = 1;
        end
        m_busy = 0;
        m_kill = 0;
      end
      if (m_fv && !stall) m_fv = 0;
      if (loaded) m_fv = 1;
      if (can_req && imem_req_ready) begin
        m_busy  = 1;
        m_raddr = m_pc;
      end
      if (redirect_valid) begin
        m_pc = redirect_pc & ~32'd3;
        m_fv = 0;
        if (m_busy) m_kill = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model fetch_valid", 32'(fetch_valid), 32'(m_fv));
      check("model instruction_out", instruction_out, m_ins);
      check("model pc_plus4_out", pc_plus4_out, m_pc4);
      check("model req_valid", 32'(imem_req_valid),
            32'(reset && !m_busy && (!m_fv || !stall) && !redirect_valid));
      check("model req_addr", imem_req_addr, m_pc);
    end
  end

  initial begin
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; imem_req_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst fetch_valid", 32'(fetch_valid), 32'd0);
    check("rst instruction_out", instruction_out, 32'd0);
    check("rst pc_plus4_out", pc_plus4_out, 32'd0);
    check("rst req_valid", 32'(imem_req_valid), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("first req_valid", 32'(imem_req_valid), 32'd1);
    check("first req_addr", imem_req_addr, 32'h100);

    @(posedge clk);
    @(posedge clk); #1 stall = 1'b1;
    @(negedge clk);
    check("stream fetch_valid", 32'(fetch_valid), 32'd1);
    check("stream instruction", instruction_out, 32'hAAAA_0001);
    check("stream pc_plus4", pc_plus4_out, 32'h104);
    check("stream next addr", imem_req_addr, 32'h104);
    check("stall req_valid", 32'(imem_req_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall hold instr", instruction_out, 32'hAAAA_0001);
      check("stall hold valid", 32'(fetch_valid), 32'd1);
    end
    @(posedge clk); #1 stall = 1'b0;
    @(negedge clk);
    check("unstall req_valid", 32'(imem_req_valid), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("consumed fetch_valid", 32'(fetch_valid), 32'd0);
    mem_delay = 2;
    @(posedge clk);
    @(negedge clk);
    check("second instruction", instruction_out, 32'hC0DE_0104);
    check("second pc_plus4", pc_plus4_out, 32'h108);

    // Redirect while the request for 0x108 is outstanding.
    @(posedge clk); #1 begin redirect_valid = 1'b1; redirect_pc = 32'h2003; end
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    mem_delay = 1;
    check("wait redirect addr", imem_req_addr, 32'h2000);
    @(posedge clk);
    @(negedge clk);
    check("killed resp dropped", 32'(fetch_valid), 32'd0);
    check("post-kill req_valid", 32'(imem_req_valid), 32'd1);
    check("post-kill req_addr", imem_req_addr, 32'h2000);

    // Redirect while a buffered instruction is held by stall.
    @(posedge clk); #1 stall = 1'b1;
    @(posedge clk); #1 begin redirect_valid = 1'b1; redirect_pc = 32'h3000; end
    @(negedge clk);
    check("held instr 0x2000", instruction_out, 32'hC0DE_2000);
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    check("stall flush valid", 32'(fetch_valid), 32'd0);
    check("stall flush keeps instr", instruction_out, 32'hC0DE_2000);
    check("stall flush addr", imem_req_addr, 32'h3000);

    // Redirect coincident with the response.
    @(posedge clk); #1 begin redirect_valid = 1'b1; redirect_pc = 32'h4000; end
    @(posedge clk); #1 begin redirect_valid = 1'b0; stall = 1'b0; end
    @(negedge clk);
    check("coincident addr", imem_req_addr, 32'h4000);
    @(posedge clk);
    @(posedge clk); #1 begin redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; end
    @(negedge clk);
    check("no stale kill instr", instruction_out, 32'hC0DE_4000);
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    check("wrap addr", imem_req_addr, 32'hFFFF_FFFC);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("wrap instr", instruction_out, 32'h3F21_FFFC);
    check("wrap pc_plus4", pc_plus4_out, 32'd0);
    check("wrap next addr", imem_req_addr, 32'd0);

    // Reset while waiting; the late reply arrives once the unit is back in REQ.
    mem_delay = 3;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 begin reset = 1'b1; imem_req_ready = 1'b0; end
    @(negedge clk);
    mem_delay = 1;
    check("midreset addr", imem_req_addr, RPC);
    check("midreset valid", 32'(fetch_valid), 32'd0);
    @(posedge clk);
    @(posedge clk); #1 imem_req_ready = 1'b1;
    @(negedge clk);
    check("late resp ignored", 32'(fetch_valid), 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("restart instr", instruction_out, 32'hAAAA_0001);
    check("restart pc_plus4", pc_plus4_out, 32'h104);
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction fetch stage that drives the IF/ID pipeline register. It owns the PC, issues one instruction-memory request at a time over a valid/ready handshake, and captures the response into an output buffer. The buffer presents instruction_out/pc_plus4_out/fetch_valid to IF/ID. The unit honours a downstream stall and a branch/jump redirect, which flushes in-flight and buffered work.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
stall  input  1  downstream cannot accept; a buffered instruction is held while 1.
redirect_valid  input  1  one-cycle pulse: branch/jump taken.
redirect_pc  input  32  redirect target; bits [1:0] ignored and forced to 0.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts request.
imem_req_addr  output  32  fetch address, equal to pc.
imem_resp_valid  input  1  one-cycle response strobe; cannot be back-pressured.
imem_resp_data  input  32  instruction word.
instruction_out  output  32  buffered instruction to IF/ID.
pc_plus4_out  output  32  address of buffered instruction + 4.
fetch_valid  output  1  buffer holds a valid instruction.

Behaviour:
- Reset (reset==0 at edge): pc<=RESET_PC, state<=REQ, kill<=0, fetch_valid<=0, instruction_out<=0, pc_plus4_out<=0. imem_req_valid is 0 while reset is low.
- Consume: the buffer is consumed on any edge where fetch_valid==1 && stall==0. fetch_valid then clears, unless a response is loaded on the same edge.
- REQ state: imem_req_valid = (!fetch_valid || !stall) && !redirect_valid. imem_resp_valid is ignored in REQ.
  - Handshake when imem_req_valid && imem_req_ready: req_pc<=pc, state<=WAIT.
  - The request is issued only when the buffer is empty or being consumed, so a response can never overwrite held data.
- WAIT state: imem_req_valid=0.
  - On imem_resp_valid with kill==0: instruction_out<=imem_resp_data, pc_plus4_out<=req_pc+4, fetch_valid<=1, pc<=req_pc+4, state<=REQ.
  - On imem_resp_valid with kill==1: drop the data, kill<=0, state<=REQ.
- Latency: response in cycle N gives fetch_valid=1 in cycle N+1. Back-to-back throughput is one instruction per 2 cycles when stall=0 and memory answers in the cycle after the handshake.
- Redirect has highest priority in every state:
  - pc<=redirect_pc & ~3.
  - fetch_valid<=0 (flushes the buffer even if stall==1); instruction_out/pc_plus4_out keep their old values.
  - In WAIT, or in REQ with a handshake on the same edge: kill<=1, state<=WAIT, so the next response is discarded.
  - Redirect and resp_valid on the same edge in WAIT: the response is discarded, kill stays 0, state<=REQ fetching redirect_pc.
  - A second redirect while kill==1 updates pc only; a single kill covers the one outstanding request.
- Arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 = 0.
- Reset mid-operation (state WAIT): return to REQ; a late response is ignored because REQ ignores imem_resp_valid.

Test Plan:
- Reset: hold reset=0 for 2 cycles, RESET_PC=0x100 -> first request addr=0x100, fetch_valid=0, outputs 0.
- Streaming: ready=1 always, response 1 cycle after handshake with data 0xAAAA0001 at pc 0x100 -> fetch_valid=1, instruction_out=0xAAAA0001, pc_plus4_out=0x104, next request addr=0x104.
- Stall: buffer valid, stall=1 for 5 cycles -> imem_req_valid=0 and outputs constant. After stall drops, request issues that same cycle and the buffer clears at the edge.
- Redirect in WAIT: redirect_pc=0x2003 while waiting -> next response dropped (fetch_valid stays 0), then request addr=0x2000.
- Redirect with stall: buffer valid, stall=1, redirect_valid=1 -> fetch_valid=0 next cycle, next request addr=redirect target.
- Wrap plus mid-WAIT reset: fetch at 0xFFFFFFFC -> pc_plus4_out=0 and next addr=0. Assert reset during WAIT with a late response -> response ignored, restart at RESET_PC.
